// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single-port data memory between the CPU MEM stage and a
//   DMA/loader requester. The CPU has priority. After STARVE_MAX consecutive
//   cycles in which the CPU beats a waiting DMA request, one slot is forced to
//   the DMA and the CPU is stalled for that cycle.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata     MEM-stage access request
//   cpu_rdata                load data (straight from mem_rdata)
//   cpu_stall                CPU access not granted this cycle
//   dma_req_valid/ready      DMA request handshake
//   dma_we/addr/wdata        DMA request payload (1 = write)
//   dma_rsp_valid/rdata      registered read response, one cycle after accept
//   mem_rd/wr/addr/wdata     to the data memory
//   mem_rdata                from the data memory, valid in the mem_rd cycle
//   stall_cnt                saturating count of CPU stall cycles
module dm_port_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Keep the counter at least one bit wide so STARVE_MAX=0 still elaborates.
    localparam int          SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          force_slot;
    logic [SW-1:0] starve;
    logic          cpu_acc;
    logic          cpu_gnt;
    logic          dma_gnt;
    logic          contended;

    always_comb begin
        cpu_acc = cpu_rd | cpu_wr;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (force_slot && dma_req_valid) dma_gnt = 1'b1;
            else if (cpu_acc)                 cpu_gnt = 1'b1;
            else if (dma_req_valid)           dma_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dma_gnt) begin
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            mem_rd = cpu_rd;
            mem_wr = cpu_wr;
        end
    end

    assign cpu_rdata     = mem_rdata;
    assign cpu_stall     = cpu_acc & dma_gnt;
    assign dma_req_ready = dma_gnt;
    assign contended     = dma_req_valid & cpu_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            force_slot    <= 1'b0;
            starve        <= '0;
            dma_rsp_valid <= 1'b0;
            dma_rdata     <= '0;
            stall_cnt     <= '0;
        end else begin
            dma_rsp_valid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;

            if (cpu_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;

            // A contended cycle can never coincide with force_slot=1 (a waiting
            // DMA wins then), so the forced slot always lasts exactly one cycle.
            if (STARVE_MAX == 0) begin
                starve     <= '0;
                force_slot <= 1'b0;
            end else if (contended) begin
                if (starve != STARVE_LIM) starve <= starve + 1'b1;
                force_slot <= (starve == STARVE_LIM - 1'b1);
            end else begin
                starve     <= '0;
                force_slot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Two arbiters side by side: dut0 with STARVE_MAX=4 and a 4-bit stall
//   counter (so saturation is reachable), dut1 with STARVE_MAX=0. Each has its
//   own memory and its own stimulus stream; a per-cycle reference model
//   predicts every output from the arbitration rules.
module tb_dm_port_arbiter;

    logic        clk;
    logic        rst;
    logic        init_mem;

    logic        cpu_rd    [2];
    logic        cpu_wr    [2];
    logic [6:0]  cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_stall [2];
    logic        dma_v     [2];
    logic        dma_rdy   [2];
    logic        dma_we    [2];
    logic [6:0]  dma_addr  [2];
    logic [31:0] dma_wdata [2];
    logic        rsp_v     [2];
    logic [31:0] rsp_data  [2];
    logic        mem_rd    [2];
    logic        mem_wr    [2];
    logic [6:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [3:0]  stall_cnt0;
    logic [15:0] stall_cnt1;

    logic [31:0] dm [2][128];

    // reference model state
    bit          m_force  [2];
    int          m_wins   [2];
    bit          m_rsp    [2];
    logic [31:0] m_rdata  [2];
    int          m_stalls [2];
    logic [31:0] ref_mem  [2][128];
    bit          cpu_hold [2];
    bit          dma_hold [2];

    int checks;
    int errors;

    dm_port_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_MAX(4), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
        .dma_req_valid(dma_v[0]), .dma_req_ready(dma_rdy[0]), .dma_we(dma_we[0]),
        .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
        .dma_rsp_valid(rsp_v[0]), .dma_rdata(rsp_data[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .stall_cnt(stall_cnt0)
    );

    dm_port_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_MAX(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
        .dma_req_valid(dma_v[1]), .dma_req_ready(dma_rdy[1]), .dma_we(dma_we[1]),
        .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
        .dma_rsp_valid(rsp_v[1]), .dma_rdata(rsp_data[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .stall_cnt(stall_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k, input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101 + 32'(k);
    endfunction

    // Single-port memory with combinational read, write on the clock edge.
    assign mem_rdata[0] = dm[0][mem_addr[0]];
    assign mem_rdata[1] = dm[1][mem_addr[1]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) begin
                dm[0][i] <= init_word(0, i);
                dm[1][i] <= init_word(1, i);
            end
        end else begin
            if (mem_wr[0]) dm[0][mem_addr[0]] <= mem_wdata[0];
            if (mem_wr[1]) dm[1][mem_addr[1]] <= mem_wdata[1];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare every output against the rules, then advance the model by one edge.
    task automatic eval_all();
        for (int k = 0; k < 2; k++) begin
            logic        acc, gd, gc, e_rd, e_wr;
            logic [6:0]  e_addr;
            logic [31:0] e_wd, sc;
            int          smax, cmax, e_sc;
            smax = (k == 0) ? 4 : 0;
            cmax = (k == 0) ? 15 : 65535;
            sc   = (k == 0) ? 32'(stall_cnt0) : 32'(stall_cnt1);
            acc  = cpu_rd[k] | cpu_wr[k];
            gd   = 1'b0;
            gc   = 1'b0;
            if (!rst) begin
                if (m_force[k] && dma_v[k]) gd = 1'b1;
                else if (acc)               gc = 1'b1;
                else if (dma_v[k])          gd = 1'b1;
            end
            e_rd   = gd ? ~dma_we[k] : (gc & cpu_rd[k]);
            e_wr   = gd ? dma_we[k]  : (gc & cpu_wr[k]);
            e_addr = gd ? dma_addr[k]  : cpu_addr[k];
            e_wd   = gd ? dma_wdata[k] : cpu_wdata[k];
            e_sc   = (m_stalls[k] > cmax) ? cmax : m_stalls[k];

            check_eq($sformatf("cpu_stall%0d", k), 32'(cpu_stall[k]), 32'(acc & gd));
            check_eq($sformatf("dma_ready%0d", k), 32'(dma_rdy[k]), 32'(gd));
            check_eq($sformatf("mem_rd%0d", k), 32'(mem_rd[k]), 32'(e_rd));
            check_eq($sformatf("mem_wr%0d", k), 32'(mem_wr[k]), 32'(e_wr));
            if (e_rd || e_wr) check_eq($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(e_addr));
            if (e_wr) check_eq($sformatf("mem_wdata%0d", k), mem_wdata[k], e_wd);
            if (gc && cpu_rd[k])
                check_eq($sformatf("cpu_rdata%0d", k), cpu_rdata[k], ref_mem[k][cpu_addr[k]]);
            check_eq($sformatf("rsp_valid%0d", k), 32'(rsp_v[k]), 32'(m_rsp[k]));
            if (m_rsp[k]) check_eq($sformatf("rsp_data%0d", k), rsp_data[k], m_rdata[k]);
            check_eq($sformatf("stall_cnt%0d", k), sc, 32'(e_sc));

            if (rst) begin
                m_force[k]  = 1'b0;
                m_wins[k]   = 0;
                m_rsp[k]    = 1'b0;
                m_rdata[k]  = '0;
                m_stalls[k] = 0;
            end else begin
                m_rsp[k] = gd & ~dma_we[k];
                if (m_rsp[k]) m_rdata[k] = ref_mem[k][dma_addr[k]];
                if (acc && gd) m_stalls[k]++;
                if (dma_v[k] && gc) m_wins[k]++;
                else                m_wins[k] = 0;
                m_force[k] = (smax > 0) && (m_wins[k] == smax);
                if (e_wr) ref_mem[k][e_addr] = e_wd;
            end
            cpu_hold[k] = acc & gd;
            dma_hold[k] = dma_v[k] & ~gd;
        end
    endtask

    // Scripted cycle: identical inputs to both instances.
    task automatic scr(input logic r, input logic crd, input logic cwr, input logic [6:0] ca,
                       input logic [31:0] cw, input logic dv, input logic dwe,
                       input logic [6:0] da, input logic [31:0] dw);
        @(negedge clk);
        rst = r;
        for (int k = 0; k < 2; k++) begin
            cpu_rd[k] = crd; cpu_wr[k] = cwr; cpu_addr[k] = ca; cpu_wdata[k] = cw;
            dma_v[k] = dv; dma_we[k] = dwe; dma_addr[k] = da; dma_wdata[k] = dw;
        end
        #1 eval_all();
    endtask

    // Random cycle honouring the hold rules; mode 1 keeps both sides busy.
    task automatic rnd(input int mode);
        @(negedge clk);
        rst = (mode == 0) && ($urandom_range(0, 149) == 0);
        for (int k = 0; k < 2; k++) begin
            int op;
            if (!cpu_hold[k]) begin
                op = (mode == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                cpu_rd[k]    = (op == 1) || (op == 2);
                cpu_wr[k]    = (op == 3);
                cpu_addr[k]  = 7'($urandom_range(0, 7));
                cpu_wdata[k] = $urandom;
            end
            if (!dma_hold[k]) begin
                dma_v[k]     = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                dma_we[k]    = 1'($urandom_range(0, 1));
                dma_addr[k]  = 7'($urandom_range(0, 7));
                dma_wdata[k] = $urandom;
            end
        end
        #1 eval_all();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        init_mem = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cpu_rd[k] = 0; cpu_wr[k] = 0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dma_v[k] = 0; dma_we[k] = 0; dma_addr[k] = '0; dma_wdata[k] = '0;
            m_force[k] = 0; m_wins[k] = 0; m_rsp[k] = 0; m_rdata[k] = '0; m_stalls[k] = 0;
            cpu_hold[k] = 0; dma_hold[k] = 0;
            for (int i = 0; i < 128; i++) ref_mem[k][i] = init_word(k, i);
        end

        scr(1, 0, 0, 0, 0, 0, 0, 0, 0);
        scr(1, 0, 0, 0, 0, 0, 0, 0, 0);
        init_mem = 1'b0;
        scr(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // CPU only: store then load at address 3
        scr(0, 0, 1, 3, 32'h1234_5678, 0, 0, 0, 0);
        scr(0, 1, 0, 3, 0, 0, 0, 0, 0);
        check_eq("t1_lw_data", cpu_rdata[0], 32'h1234_5678);
        check_eq("t1_no_stall", 32'(cpu_stall[0]), 32'd0);
        scr(0, 1, 0, 3, 0, 0, 0, 0, 0);
        check_eq("t1_lw_data_b", cpu_rdata[1], 32'h1234_5678);

        // DMA only: write then read address 5
        scr(0, 0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF);
        check_eq("t2_wr_ready", 32'(dma_rdy[0]), 32'd1);
        scr(0, 0, 0, 0, 0, 1, 0, 5, 0);
        check_eq("t2_rd_ready", 32'(dma_rdy[0]), 32'd1);
        check_eq("t2_no_rsp_yet", 32'(rsp_v[0]), 32'd0);
        scr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t2_rsp_valid", 32'(rsp_v[0]), 32'd1);
        check_eq("t2_rsp_data", rsp_data[0], 32'hDEAD_BEEF);
        scr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t2_rsp_pulse", 32'(rsp_v[0]), 32'd0);

        // Same address: CPU store wins, DMA read of it follows
        scr(0, 0, 1, 7, 32'hA5A5_A5A5, 1, 0, 7, 0);
        check_eq("t6_dma_wait", 32'(dma_rdy[0]), 32'd0);
        scr(0, 0, 0, 0, 0, 1, 0, 7, 0);
        check_eq("t6_dma_gnt", 32'(dma_rdy[0]), 32'd1);
        scr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t6_rsp_data", rsp_data[0], 32'hA5A5_A5A5);

        // Continuous contention: forced slots at cycles 4 and 9 only for dut0
        for (int i = 0; i < 10; i++) begin
            rnd(1);
            check_eq($sformatf("t3_ready_c%0d", i), 32'(dma_rdy[0]), 32'((i == 4) || (i == 9)));
            check_eq($sformatf("t3_stall_c%0d", i), 32'(cpu_stall[0]), 32'((i == 4) || (i == 9)));
            check_eq($sformatf("t4_ready_c%0d", i), 32'(dma_rdy[1]), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cpu_rd[k] = 1'b0;
            cpu_wr[k] = 1'b0;
        end
        #1 eval_all();
        check_eq("t4_ready_idle", 32'(dma_rdy[1]), 32'd1);
        check_eq("t3_stall_cnt", 32'(stall_cnt0), 32'd2);
        check_eq("t4_stall_cnt", 32'(stall_cnt1), 32'd0);

        // Reset right after a DMA read is accepted
        scr(0, 0, 0, 0, 0, 1, 0, 5, 0);
        check_eq("t5_accept", 32'(dma_rdy[0]), 32'd1);
        scr(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t5_rst_ready", 32'(dma_rdy[0]), 32'd0);
        scr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t5_rsp_dropped", 32'(rsp_v[0]), 32'd0);
        check_eq("t5_rdata_clr", rsp_data[0], 32'd0);
        check_eq("t5_stall_clr", 32'(stall_cnt0), 32'd0);

        // Long contention burst drives dut0's counter into saturation
        for (int i = 0; i < 200; i++) rnd(1);
        check_eq("sat_stall_cnt", 32'(stall_cnt0), 32'd15);

        for (int i = 0; i < 3000; i++) rnd((i % 500 < 60) ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
